// File: rtl/seg_pkg.sv
// +----------------------------------------------------------------------------+
// | seg_pkg: shared constants, scan FSM states and digit helpers for the       |
// | 4-digit 7-segment scan controller.                                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    function automatic logic [3:0] get_digit(input logic [15:0] v, input logic [1:0] k);
        return v[{k, 2'b00} +: 4];
    endfunction

    // True when digit k and every more-significant digit are zero; digit 0 never qualifies.
    function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] k);
        case (k)
            2'd1:    return (v[15:4]  == 12'h000);
            2'd2:    return (v[15:8]  == 8'h00);
            2'd3:    return (v[15:12] == 4'h0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl_if: value/control inputs and display pin outputs of the      |
// | scan controller.                                                           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface seg_scan_ctrl_if;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output enable, load, value, dp_en, blank_lz,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  enable, load, value, dp_en, blank_lz,
        output an, seg, dp, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_ctrl_display.sv
// +----------------------------------------------------------------------------+
// | display: BCD to active-low 7-segment decoder, o_seg[6] = a .. o_seg[0] = g.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module display (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_bcd)
            4'd0:    o_seg = 7'b0000001;
            4'd1:    o_seg = 7'b1001111;
            4'd2:    o_seg = 7'b0010010;
            4'd3:    o_seg = 7'b0000110;
            4'd4:    o_seg = 7'b1001100;
            4'd5:    o_seg = 7'b0100100;
            4'd6:    o_seg = 7'b0100000;
            4'd7:    o_seg = 7'b0001111;
            4'd8:    o_seg = 7'b0000000;
            4'd9:    o_seg = 7'b0000100;
            default: o_seg = 7'b0000001;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | seg_scan_ctrl: time-multiplexed 4-digit scan with dead time, leading-zero  |
// | blanking and frame-aligned value updates.                                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    seg_scan_ctrl_if.slave  bus
);
    localparam int             CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLEND = CNT_W'(BLANK_CYC - 1);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_flag_q, pend_flag_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;

    logic             boundary;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg_dec;
    logic             w_lz;
    logic             w_lit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        slot_d   = slot_q;
        boundary = bus.enable && (cnt_q == CNT_LAST) && (slot_q == 2'd3);
        if (!bus.enable) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            slot_d  = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            slot_d  = slot_q + 2'd1;
        end else if (state_q == S_BLANK && cnt_q == CNT_BLEND) begin
            state_d = S_ON;
        end

        // While dark nothing is visible, so the shadow can follow pending freely.
        shadow_d    = (!bus.enable || (boundary && pend_flag_q)) ? pending_q : shadow_q;
        pending_d   = bus.load ? bus.value : pending_q;
        pend_flag_d = bus.load || (pend_flag_q && bus.enable && !boundary);
    end

    assign w_nib = get_digit(shadow_d, slot_d);

    display u_display (
        .i_bcd (w_nib),
        .o_seg (w_seg_dec)
    );

    always_comb begin
        w_lz         = bus.blank_lz && lz_blank(shadow_d, slot_d);
        w_lit        = bus.enable && (state_d == S_ON) && !w_lz;
        an_d         = w_lit ? ~(4'b0001 << slot_d) : AN_OFF;
        seg_d        = (!bus.enable || w_lz) ? SEG_BLANK : w_seg_dec;
        dp_d         = w_lit ? ~bus.dp_en[slot_d] : 1'b1;
        frame_done_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            slot_q       <= 2'd0;
            shadow_q     <= 16'h0000;
            pending_q    <= 16'h0000;
            pend_flag_q  <= 1'b0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_flag_q  <= pend_flag_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl (REFRESH_DIV=16,      |
// | BLANK_CYC=2) with per-scenario directed checks.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_scan_ctrl;
    localparam int RD    = 16;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [12:0] exp_q[$];
    logic [12:0] sb_e;

    // Reference model: position inside the frame plus the two value registers.
    int          pos = 0;
    logic [15:0] m_shadow = 16'h0, m_pending = 16'h0;
    logic        m_pflag = 1'b0;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd1: return 7'b1001111;  4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;  4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;  4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;  4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;  default: return 7'b0000001;
        endcase
    endfunction

    // Predict the outputs after the coming edge, queue them, then advance one cycle.
    task automatic tick();
        logic [12:0] e;
        logic        bnd, blk, lit;
        int          slot, off;
        if (!rst_n) begin
            pos = 0; m_shadow = 16'h0; m_pending = 16'h0; m_pflag = 1'b0;
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else if (!bus.enable) begin
            m_shadow = m_pending;
            m_pflag  = bus.load;
            if (bus.load) m_pending = bus.value;
            pos = 0;
            e = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else begin
            bnd = (pos == FRAME - 1);
            if (bnd && m_pflag) begin m_shadow = m_pending; m_pflag = 1'b0; end
            if (bus.load) begin m_pending = bus.value; m_pflag = 1'b1; end
            pos  = (pos + 1) % FRAME;
            slot = pos / RD;
            off  = pos % RD;
            blk  = bus.blank_lz && (slot > 0) && ((m_shadow >> (slot * 4)) == 16'h0);
            lit  = (off >= BC) && !blk;
            e[12:9] = lit ? ~(4'b0001 << slot) : 4'hF;
            e[8:2]  = blk ? 7'h7F : dec(m_shadow[slot*4 +: 4]);
            e[1]    = lit ? ~bus.dp_en[slot] : 1'b1;
            e[0]    = bnd;
        end
        exp_q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < 2 * FRAME && pos != target; i++) tick();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            sb_e = exp_q.pop_front();
            n_tests++;
            if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== sb_e) begin
                n_fail++;
                $display("FAIL scoreboard cyc=%0d got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                         cyc, bus.an, bus.seg, bus.dp, bus.frame_done,
                         sb_e[12:9], sb_e[8:2], sb_e[1], sb_e[0]);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; bus.enable = 1'b1; bus.load = 1'b0; bus.value = 16'h0;
        bus.dp_en = 4'h0; bus.blank_lz = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got %b want %b",
                     {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan();
        int errs = 0, nfd = 0, first_fd = -1, last_fd = -1;
        logic [3:0] an_exp;
        for (int i = 1; i < 34; i++) begin
            tick();
            an_exp = (i % RD < BC) ? 4'hF : ((i < RD) ? 4'b1110 : 4'b1101);
            if (bus.an !== an_exp || (bus.an !== 4'hF && bus.seg !== 7'b0000001)) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL scan_sequence got %0d bad cycles want 0", errs);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (bus.frame_done === 1'b1) begin
                nfd++;
                if (first_fd < 0) first_fd = i;
                last_fd = i;
            end
        end
        n_tests++;
        if (nfd != 2 || last_fd - first_fd != FRAME) begin
            n_fail++;
            $display("FAIL frame_done_period got %0d pulses spacing %0d want 2 pulses spacing %0d",
                     nfd, last_fd - first_fd, FRAME);
        end
    endtask

    task automatic test_load();
        logic [6:0] want [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        int errs = 0;
        run_to(34);
        bus.load = 1'b1; bus.value = 16'h1234; tick(); bus.load = 1'b0;
        while (pos != 0 && errs < 1000) begin
            tick();
            if (pos != 0 && bus.an !== 4'hF && bus.seg !== 7'b0000001) errs++;
        end
        n_tests++;
        if (errs != 0 || bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL load_tearfree got %0d early changes fd=%b want 0 and fd=1", errs, bus.frame_done);
        end
        errs = 0;
        repeat (FRAME - 1) begin
            tick();
            if (pos % RD >= BC && bus.seg !== want[pos / RD]) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL load_1234_digits got %0d wrong cycles want 0", errs);
        end
    endtask

    task automatic test_overwrite();
        logic [6:0] w42  [4] = '{7'b0010010, 7'b1001100, 7'b0000001, 7'b0000001};
        logic [6:0] w777 [4] = '{7'b0001111, 7'b0001111, 7'b0001111, 7'b0000001};
        int errs = 0;
        run_to(10);
        bus.load = 1'b1; bus.value = 16'h0001; tick(); bus.load = 1'b0;
        run_to(30);
        bus.load = 1'b1; bus.value = 16'h0042; tick(); bus.load = 1'b0;
        run_to(FRAME - 1);
        // This load coincides with the boundary edge itself.
        bus.load = 1'b1; bus.value = 16'h0777; tick(); bus.load = 1'b0;
        repeat (FRAME - 1) begin
            tick();
            if (pos % RD >= BC && bus.seg !== w42[pos / RD]) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL overwrite_0042 got %0d wrong cycles want 0", errs);
        end
        errs = 0;
        tick();
        repeat (FRAME - 1) begin
            tick();
            if (pos % RD >= BC && bus.seg !== w777[pos / RD]) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL collision_0777 got %0d wrong cycles want 0", errs);
        end
    endtask

    task automatic test_lz();
        logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0A05};
        logic [6:0]  d0   [3] = '{7'b0100100, 7'b0000001, 7'b0100100};
        logic [3:0]  onmask;
        int errs;
        bus.blank_lz = 1'b1;
        for (int v = 0; v < 3; v++) begin
            errs = 0; onmask = 4'h0;
            run_to(5);
            bus.load = 1'b1; bus.value = vals[v]; tick(); bus.load = 1'b0;
            run_to(0);
            repeat (FRAME) begin
                tick();
                onmask = onmask | ~bus.an;
                if (pos / RD == 0 && pos % RD >= BC && bus.seg !== d0[v]) errs++;
                if (v == 2 && pos / RD == 2 && pos % RD >= BC && bus.seg !== 7'b0000001) errs++;
            end
            n_tests++;
            if (errs != 0 || onmask !== ((v == 2) ? 4'b0111 : 4'b0001)) begin
                n_fail++;
                $display("FAIL lz_blank_%h got %0d bad cycles lit_mask=%b want 0 and %b",
                         vals[v], errs, onmask, (v == 2) ? 4'b0111 : 4'b0001);
            end
        end
        bus.blank_lz = 1'b0;
    endtask

    task automatic test_dp();
        int errs = 0;
        bus.dp_en = 4'b0100;
        run_to(0);
        repeat (FRAME) begin
            tick();
            if (bus.dp !== ((pos / RD == 2 && pos % RD >= BC) ? 1'b0 : 1'b1)) errs++;
        end
        n_tests++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL dp_slot2 got %0d wrong cycles want 0", errs);
        end
        bus.dp_en = 4'h0;
    endtask

    task automatic test_disable_reset();
        run_to(40);
        bus.enable = 1'b0; tick();
        n_tests++;
        if (bus.an !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_dark got an=%b seg=%b dp=%b want 1111 1111111 1", bus.an, bus.seg, bus.dp);
        end
        bus.load = 1'b1; bus.value = 16'h9999; tick(); bus.load = 1'b0;
        repeat (2) tick();
        bus.enable = 1'b1; tick();
        n_tests++;
        if (bus.an !== 4'hF) begin
            n_fail++;
            $display("FAIL reenable_blank got an=%b want 1111", bus.an);
        end
        tick();
        n_tests++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'b0000100) begin
            n_fail++;
            $display("FAIL reenable_9999 got an=%b seg=%b want 1110 0000100", bus.an, bus.seg);
        end
        run_to(52);
        rst_n = 1'b0; tick();
        n_tests++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL midscan_reset got %b want %b",
                     {bus.an, bus.seg, bus.dp, bus.frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        repeat (RD) tick();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_overwrite();
        test_lz();
        test_dp();
        test_disable_reset();
        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout at cyc=%0d want completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
